// File: rtl/wb_ctrl.sv
// Writeback controller: merges ALU results and buffered memory responses into the
// single regfile write port and tracks in-flight load destinations for hazard stalls.
module wb_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            stall,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] indata,
  output logic            we,
  output logic [31:0]     pending
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          fifo_mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            src_mem;
  logic            push;
  logic            pop;
  logic [31:0]     pending_nxt;

  assign mem_ready = (count != CW'(DEPTH)) && !reset;
  assign push      = mem_valid && mem_ready;
  // ALU results always win the write port; the FIFO drains only in idle ALU cycles.
  assign pop       = !alu_valid && (count != '0);
  assign head      = fifo_mem[rd_ptr];

  // Storage needs no reset: occupancy count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr].rd   <= mem_rd;
      fifo_mem[wr_ptr].data <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output register; writes to x0 are consumed but never enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we      <= 1'b0;
      rd      <= '0;
      indata  <= '0;
      src_mem <= 1'b0;
    end else if (alu_valid) begin
      we      <= (alu_rd != 5'd0);
      rd      <= alu_rd;
      indata  <= alu_data;
      src_mem <= 1'b0;
    end else if (pop) begin
      we      <= (head.rd != 5'd0);
      rd      <= head.rd;
      indata  <= head.data;
      src_mem <= 1'b1;
    end else begin
      we      <= 1'b0;
      src_mem <= 1'b0;
    end
  end

  // Clear on the edge the regfile captures a load result; a same-edge issue wins.
  always_comb begin
    pending_nxt = pending;
    if (we && src_mem) pending_nxt[rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  always_comb begin
    stall = 1'b0;
    if ((rs1 != 5'd0) && pending[rs1]) stall = 1'b1;
    if ((rs2 != 5'd0) && pending[rs2]) stall = 1'b1;
    if (issue_valid && (issue_rd != 5'd0) && pending[issue_rd]) stall = 1'b1;
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed self-checking bench for wb_ctrl with a small regfile model on the write port.
module tb_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic [4:0]  rd;
  logic [31:0] indata;
  logic        we;
  logic [31:0] pending;

  logic [31:0] regs [32];
  int n_assert = 0;
  int n_fail   = 0;

  wb_ctrl #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .stall(stall), .rd(rd), .indata(indata), .we(we), .pending(pending)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (we) regs[rd] <= indata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    tick(); tick();
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_indata", 64'(indata), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_ready", 64'(mem_ready), 64'd0);
    reset = 1'b0;
    #1 chk("rel_ready", 64'(mem_ready), 64'd1);

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    chk("alu_we", 64'(we), 64'd1);
    chk("alu_rd", 64'(rd), 64'd5);
    chk("alu_data", 64'(indata), 64'hDEADBEEF);
    tick();
    chk("alu_we_off", 64'(we), 64'd0);
    chk("alu_rd_hold", 64'(rd), 64'd5);
    chk("alu_regfile", 64'(regs[5]), 64'hDEADBEEF);

    // Load hazard on x7
    issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
    #1 chk("ld_stall_pre", 64'(stall), 64'd0);
    tick();
    issue_valid = 1'b0;
    chk("ld_pending_set", 64'(pending), 64'h80);
    chk("ld_stall", 64'(stall), 64'd1);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234;
    tick();
    mem_valid = 1'b0;
    chk("ld_N_we", 64'(we), 64'd0);
    chk("ld_N_pending", 64'(pending), 64'h80);
    tick();
    chk("ld_N1_we", 64'(we), 64'd1);
    chk("ld_N1_rd", 64'(rd), 64'd7);
    chk("ld_N1_data", 64'(indata), 64'h1234);
    chk("ld_N1_pending", 64'(pending), 64'h80);
    chk("ld_N1_stall", 64'(stall), 64'd1);
    tick();
    chk("ld_N2_pending", 64'(pending), 64'h0);
    chk("ld_N2_stall", 64'(stall), 64'd0);
    chk("ld_regfile", 64'(regs[7]), 64'h1234);
    rs1 = '0;

    // ALU priority with FIFO fill and backpressure
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(1 + i); alu_data = 32'h00B0 + 32'(i);
      mem_valid = 1'b1; mem_rd = 5'(16 + ((i < 4) ? i : 4)); mem_data = 32'hA000 + 32'((i < 4) ? i : 4);
      #1 chk($sformatf("bp_ready_%0d", i), 64'(mem_ready), (i < 4) ? 64'd1 : 64'd0);
      tick();
      chk($sformatf("bp_alu_rd_%0d", i), 64'(rd), 64'(1 + i));
      chk($sformatf("bp_alu_data_%0d", i), 64'(indata), 64'h00B0 + 64'(i));
    end
    alu_valid = 1'b0;
    #1 chk("bp_full_ready", 64'(mem_ready), 64'd0);
    tick();
    chk("bp_m0_rd", 64'(rd), 64'd16);
    chk("bp_m0_data", 64'(indata), 64'hA000);
    chk("bp_after_pop_ready", 64'(mem_ready), 64'd1);
    tick();
    mem_valid = 1'b0;
    chk("bp_m1_rd", 64'(rd), 64'd17);
    for (int k = 2; k < 5; k++) begin
      tick();
      chk($sformatf("bp_m%0d_we", k), 64'(we), 64'd1);
      chk($sformatf("bp_m%0d_rd", k), 64'(rd), 64'(16 + k));
      chk($sformatf("bp_m%0d_data", k), 64'(indata), 64'hA000 + 64'(k));
    end
    tick();
    chk("bp_drained_we", 64'(we), 64'd0);

    // Writes to x0
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    tick();
    alu_valid = 1'b0;
    chk("x0_alu_we", 64'(we), 64'd0);
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hEEEE;
    tick();
    mem_valid = 1'b0;
    tick();
    chk("x0_mem_we", 64'(we), 64'd0);
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
    tick();
    mem_valid = 1'b0;
    tick();
    chk("x0_popped_rd", 64'(rd), 64'd3);
    chk("x0_popped_we", 64'(we), 64'd1);
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1 chk("x0_issue_stall", 64'(stall), 64'd0);
    tick();
    issue_valid = 1'b0;
    chk("x0_issue_pending", 64'(pending), 64'd0);

    // Issue to x9 on the same edge a FIFO write to x9 commits
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    rs2 = 5'd9;
    chk("sim_rs2_stall", 64'(stall), 64'd1);
    rs2 = '0;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    tick();
    mem_valid = 1'b0;
    tick();
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1 chk("sim_waw_stall", 64'(stall), 64'd1);
    tick();
    issue_valid = 1'b0;
    chk("sim_pending", 64'(pending), 64'h200);
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h98;
    tick();
    mem_valid = 1'b0;
    tick(); tick();
    chk("sim_cleared", 64'(pending), 64'h0);

    // Asynchronous reset mid-stream
    issue_valid = 1'b1; issue_rd = 5'd2;
    tick();
    issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    chk("mid_pending", 64'(pending), 64'h24);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_rd = 5'(20 + i); mem_data = 32'hC0 + 32'(i);
      tick();
    end
    mem_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_we", 64'(we), 64'd0);
    chk("mid_rst_rd", 64'(rd), 64'd0);
    chk("mid_rst_indata", 64'(indata), 64'd0);
    chk("mid_rst_pending", 64'(pending), 64'd0);
    chk("mid_rst_ready", 64'(mem_ready), 64'd0);
    alu_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1 chk("mid_rel_ready", 64'(mem_ready), 64'd1);
    tick();
    chk("mid_nowrite1", 64'(we), 64'd0);
    tick();
    chk("mid_nowrite2", 64'(we), 64'd0);
    chk("mid_pending_end", 64'(pending), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback controller on the write side of the register file. Merges single-cycle ALU results and buffered multi-cycle load/memory responses into the register file's single write port (rd, indata, we), one write per cycle. Keeps a scoreboard of destinations with loads in flight and raises a hazard stall to decode until each load result has committed.

## Interface

Parameters
- DEPTH, 4, number of entries in the memory-response FIFO (power of two, ≥2)
- XLEN, 32, data width

Ports
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- mem_valid  in  1  memory response offered
- mem_ready  out  1  FIFO can accept; transfer when mem_valid && mem_ready
- mem_rd  in  5  memory response destination
- mem_data  in  XLEN  memory response data
- issue_valid  in  1  decode issues a load this cycle
- issue_rd  in  5  destination of the issuing load
- rs1, rs2  in  5 each  decode source registers for hazard check
- stall  out  1  combinational hazard indication to decode
- rd  out  5  regfile write address (registered)
- indata  out  XLEN  regfile write data (registered)
- we  out  1  regfile write enable (registered)
- pending  out  32  scoreboard bitmap, bit i = load in flight to xi

## Operation

- Write selection each cycle, ALU priority:
  - alu_valid=1: load output register with {alu_rd, alu_data}, src_mem=0.
  - else FIFO non-empty: pop head, load output register with it, src_mem=1.
  - else we<=0; rd/indata hold previous values.
- Destination x0: any selected entry with rd=0 is consumed (popped if from FIFO) but we<=0.
- FIFO: DEPTH entries {rd, data}, read/write pointers wrapping modulo DEPTH, occupancy count 0..DEPTH. Push on mem_valid && mem_ready. Push and pop in the same cycle leave count unchanged; pop of the entry pushed that cycle is impossible (push visible next cycle).
- mem_ready = (count != DEPTH) && !reset; depends only on registered count.
- Scoreboard:
  - set pending[issue_rd] on issue_valid when issue_rd != 0.
  - clear pending[rd] on the edge where the regfile commits a FIFO-sourced write (we=1 && src_mem=1), i.e. same edge the regfile captures the data.
  - simultaneous set and clear of the same bit: set wins.
  - pending[0] is constant 0. ALU writes never clear bits.
- stall = (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]) || (issue_valid && issue_rd!=0 && pending[issue_rd]) (WAW guard). Decode must not issue while stall=1; protocol violation behaviour is set-wins only.
- Sustained alu_valid starves the FIFO; when full, mem_ready drops and backpressures memory. No fairness guarantee.

## Timing

- Reset (asynchronous assert, any cycle including mid-transfer): we=0, rd=0, indata=0, pending=0, count=0, pointers=0, src_mem=0, mem_ready=0 while reset high, 1 in the first cycle after release. FIFO contents discarded.
- ALU result at edge N input → we/rd/indata valid after edge N → regfile commits at edge N+1.
- Memory response accepted at edge N (empty FIFO, no ALU traffic in N+1) → popped into output at edge N+1 → regfile commits and pending bit clears at edge N+2; stall on that source drops in cycle after N+2, when regfile read returns the new value.
- Full FIFO: mem_ready low the cycle after count reaches DEPTH; rises the cycle after a pop.
- One write per cycle maximum; throughput one result/cycle.

## Test plan

- Reset: assert mid-stream with 3 FIFO entries and pending=0x0000_0024 → all outputs 0, pending=0, after release mem_ready=1, no writes.
- ALU only: alu_valid, alu_rd=5, alu_data=0xDEADBEEF at edge 0 → we=1, rd=5, indata=0xDEADBEEF after edge 0; we=0 next cycle.
- Load hazard: issue_rd=7, rs1=7 → stall=1; mem response rd=7 data=0x1234 accepted edge N with no ALU traffic → pending[7] clears at edge N+2, stall=0 afterwards, regfile x7=0x1234.
- Priority/backpressure: alu_valid held 6 cycles while memory offers 5 responses, DEPTH=4 → 4 accepted, mem_ready=0 while full; after alu_valid drops, 4 FIFO writes in order, then 5th accepted and written.
- x0: ALU and memory results to rd=0 → we stays 0; FIFO entry still popped; issue_rd=0 sets no pending bit, stall=0.
- Simultaneous: issue_rd=9 on the same edge a FIFO write to x9 commits → pending[9]=1 after edge.
